// File: rtl/barrel_shift_arbiter.sv
// Shared rotate-left unit arbitrated among R requesters, with a single registered output slot.
// Define BARREL_SHIFT_ARBITER_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module barrel_shift_arbiter #(
   parameter int N = 32,
   parameter int R = 4,
   localparam int LOGN = $clog2(N),
   localparam int IDW  = (R > 1) ? $clog2(R) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [R-1:0]      req_valid,
   output logic [R-1:0]      req_ready,
   input  logic [R*N-1:0]    req_a,
   input  logic [R*LOGN-1:0] req_amt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      out_data,
   output logic [IDW-1:0]    out_id
);

   logic            out_valid_q, out_valid_d;
   logic [N-1:0]    out_data_q, out_data_d;
   logic [IDW-1:0]  out_id_q, out_id_d;
   logic [IDW-1:0]  grant_idx;
   logic            slot_free, accept;
   logic [N-1:0]    sel_a, rot;
   logic [LOGN-1:0] sel_amt;

`ifdef BARREL_SHIFT_ARBITER_RR_EN
   logic [IDW-1:0]  p_q, p_d;
   logic            grant_found;
   int              idx;

   // Search starts at the pointer and wraps; the first valid requester wins.
   always_comb begin
      grant_idx   = '0;
      grant_found = 1'b0;
      idx         = 0;
      for (int k = 0; k < R; k++) begin
         idx = int'(p_q) + k;
         if (idx >= R) idx = idx - R;
         if (!grant_found && req_valid[IDW'(idx)]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(idx);
         end
      end
   end

   always_comb begin
      p_d = p_q;
      if (accept) p_d = (grant_idx == IDW'(R - 1)) ? '0 : grant_idx + 1'b1;
   end
`else
   always_comb begin
      grant_idx = '0;
      for (int k = R - 1; k >= 0; k--) begin
         if (req_valid[IDW'(k)]) grant_idx = IDW'(k);
      end
   end
`endif

   // Gating with rst_n keeps req_ready low throughout reset, not just after the first edge.
   assign slot_free = !out_valid_q || out_ready;
   assign accept    = rst_n && slot_free && (|req_valid);

   genvar gi;
   generate
      for (gi = 0; gi < R; gi++) begin : g_ready
         assign req_ready[gi] = accept && (grant_idx == IDW'(gi));
      end
   endgenerate

   assign sel_a   = req_a[int'(grant_idx)*N +: N];
   assign sel_amt = req_amt[int'(grant_idx)*LOGN +: LOGN];

   // Logarithmic rotator: stage s rotates by 2**s when amount bit s is set.
   always_comb begin
      rot = sel_a;
      for (int s = 0; s < LOGN; s++) begin
         if (sel_amt[s]) rot = (rot << (1 << s)) | (rot >> (N - (1 << s)));
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = rot;
         out_id_d    = grant_idx;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
`ifdef BARREL_SHIFT_ARBITER_RR_EN
         p_q         <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
`ifdef BARREL_SHIFT_ARBITER_RR_EN
         p_q         <= p_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Scoreboard bench for barrel_shift_arbiter: stimulus pushes expected results, a monitor pops them.
// Expected grant orders follow BARREL_SHIFT_ARBITER_RR_EN when it is defined for the build.
module tb_barrel_shift_arbiter;
   localparam int N    = 32;
   localparam int R    = 4;
   localparam int LOGN = 5;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [R-1:0]      req_valid;
   logic [R-1:0]      req_ready;
   logic [R*N-1:0]    req_a;
   logic [R*LOGN-1:0] req_amt;
   logic              out_valid;
   logic              out_ready;
   logic [N-1:0]      out_data;
   logic [IDW-1:0]    out_id;

   int tests_run = 0;
   int failed    = 0;
   logic [IDW+N-1:0] sb_q[$];
   logic [N-1:0]     a_tab[R];
   logic [LOGN-1:0]  amt_tab[R];

   barrel_shift_arbiter #(.N(N), .R(R)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_amt(req_amt),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_id(out_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [N-1:0] rotl_m(input logic [N-1:0] a, input logic [LOGN-1:0] amt);
      logic [N-1:0] x;
      x = a;
      for (int k = 0; k < int'(amt); k++) x = {x[N-2:0], x[N-1]};
      return x;
   endfunction

   function automatic logic [R-1:0] onehot(input int i);
      logic [R-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic set_op(input int i, input logic [N-1:0] a, input logic [LOGN-1:0] amt);
      a_tab[i]                = a;
      amt_tab[i]              = amt;
      req_a[i*N +: N]         = a;
      req_amt[i*LOGN +: LOGN] = amt;
   endtask

   // Drive one request pattern for one cycle with out_ready=1 and expect requester exp_id to win.
   task automatic issue(input logic [R-1:0] v, input int exp_id, input logic [N-1:0] exp_data);
      logic [IDW-1:0] id;
      id        = IDW'(exp_id);
      req_valid = v;
      out_ready = 1'b1;
      @(negedge clk);
      check("req_ready", N'(req_ready), N'(onehot(exp_id)));
      sb_q.push_back({id, exp_data});
      $display("[TB] issue valid=%b expect id=%0d data=0x%08h", v, exp_id, exp_data);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result", N'(1), N'(0));
         end else begin
            logic [IDW+N-1:0] e;
            e = sb_q.pop_front();
            check("out_id", N'(out_id), N'(e[IDW+N-1:N]));
            check("out_data", out_data, e[N-1:0]);
            $display("[TB] result id=%0d data=0x%08h", out_id, out_data);
         end
      end
   end

   initial begin
      int exp_id;
      logic [N-1:0] last_data;
      logic [IDW-1:0] last_id;

      rst_n     = 1'b0;
      req_valid = 4'b1111;
      out_ready = 1'b1;
      req_a     = '0;
      req_amt   = '0;
      #3;
      check("rst_out_valid", N'(out_valid), N'(0));
      check("rst_out_data", out_data, N'(0));
      check("rst_out_id", N'(out_id), N'(0));
      check("rst_req_ready", N'(req_ready), N'(0));
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single operation with wrap of the MSB.
      set_op(0, 32'h8000_0001, 5'd1);
      issue(4'b0001, 0, 32'h0000_0003);

      // Rotate bounds through different requesters.
      set_op(1, 32'h1234_5678, 5'd0);
      issue(4'b0010, 1, 32'h1234_5678);
      set_op(2, 32'h1234_5678, 5'd31);
      issue(4'b0100, 2, 32'h091A_2B3C);
      set_op(3, 32'h1234_5678, 5'd16);
      issue(4'b1000, 3, 32'h5678_1234);

      // Contention with all four requesters held.
      set_op(0, 32'hA5A5_0F0F, 5'd3);
      set_op(1, 32'h1234_5678, 5'd4);
      set_op(2, 32'hDEAD_BEEF, 5'd8);
      set_op(3, 32'h8000_0001, 5'd31);
      exp_id = 0;
      for (int k = 0; k < 8; k++) begin
`ifdef BARREL_SHIFT_ARBITER_RR_EN
         exp_id = k % R;
`else
         exp_id = 0;
`endif
         issue(4'b1111, exp_id, rotl_m(a_tab[exp_id], amt_tab[exp_id]));
      end
      last_id   = IDW'(exp_id);
      last_data = rotl_m(a_tab[exp_id], amt_tab[exp_id]);

      // Backpressure: result must hold, nothing accepted.
      out_ready = 1'b0;
      req_valid = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_req_ready", N'(req_ready), N'(0));
         check("bp_out_valid", N'(out_valid), N'(1));
         check("bp_out_data", out_data, last_data);
         check("bp_out_id", N'(out_id), N'(last_id));
         @(posedge clk); #1;
      end
      issue(4'b0010, 1, 32'h2345_6781);

      // Two held requesters, four accepts.
      for (int k = 0; k < 4; k++) begin
`ifdef BARREL_SHIFT_ARBITER_RR_EN
         exp_id = (k % 2 == 0) ? 2 : 1;
`else
         exp_id = 1;
`endif
         issue(4'b0110, exp_id, (exp_id == 2) ? 32'hADBE_EFDE : 32'h2345_6781);
      end
      req_valid = '0;
      @(posedge clk); #1;

      // Reset while a result is pending downstream.
      req_valid = 4'b0001;
      out_ready = 1'b0;
      @(negedge clk);
      check("pre_rst_req_ready", N'(req_ready), N'(4'b0001));
      @(posedge clk); #1;
      req_valid = '0;
      #2;
      check("pre_rst_out_valid", N'(out_valid), N'(1));
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", N'(out_valid), N'(0));
      check("async_rst_out_data", out_data, N'(0));
      check("async_rst_out_id", N'(out_id), N'(0));
      req_valid = 4'b1111;
      #1;
      check("async_rst_req_ready", N'(req_ready), N'(0));
      sb_q.delete();
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      issue(4'b1111, 0, rotl_m(a_tab[0], amt_tab[0]));
`ifdef BARREL_SHIFT_ARBITER_RR_EN
      exp_id = 1;
`else
      exp_id = 0;
`endif
      issue(4'b1111, exp_id, rotl_m(a_tab[exp_id], amt_tab[exp_id]));

      req_valid = '0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(posedge clk);
      @(posedge clk); #1;
      check("sb_drain", N'(sb_q.size()), N'(0));
      check("idle_out_valid", N'(out_valid), N'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end
endmodule

// File: doc/barrel_shift_arbiter.md
BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, data width in bits (power of two, >=2).
REQ-002 SHALL have parameter R, default 4, number of requesters (>=2); derived LOGN = $clog2(N) and IDW = max(1,$clog2(R)).
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  R  per-requester operation valid.
REQ-006 SHALL have port req_ready  output  R  per-requester accept strobe.
REQ-007 SHALL have port req_a  input  R*N  packed operands, requester i at bits [i*N +: N].
REQ-008 SHALL have port req_amt  input  R*LOGN  packed shift amounts, requester i at [i*LOGN +: LOGN].
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out_data  output  N  rotated result.
REQ-012 SHALL have port out_id  output  IDW  index of requester that issued the result.

Function
REQ-013 Block SHALL contain exactly one rotate-left datapath shared by all requesters: result = operand rotated left by amt, amt 0 to N-1, bits leaving MSB re-enter at LSB.
REQ-014 Output stage SHALL be one register (out_valid/out_data/out_id); latency from accept to out_valid = 1 cycle.
REQ-015 Slot free SHALL be defined as (!out_valid || out_ready); accept occurs only in a cycle where slot free and at least one req_valid is high.
REQ-016 In an accept cycle exactly one req_ready bit SHALL be high (the granted one); otherwise req_ready = 0; req_ready combinational from req_valid, out_valid, out_ready, priority pointer.
REQ-017 Transfer on requester i SHALL occur when req_valid[i] && req_ready[i]; requester holds req_a/req_amt stable while req_valid high and not accepted.
REQ-018 On accept, next cycle out_valid = 1, out_data = rotl(req_a[g], req_amt[g]), out_id = g.
REQ-019 When out_valid && !out_ready, out_data/out_id SHALL hold unchanged and req_ready = 0 (backpressure).
REQ-020 When out_valid && out_ready and no request, out_valid SHALL fall next cycle; with request, a new result SHALL load back-to-back (full throughput, 1 result/cycle).
REQ-021 Arbitration (round-robin mode): pointer p in 0..R-1; grant = first valid index searching p, p+1, ... wrapping R-1 -> 0; after grant g, p <= (g+1) mod R; p unchanged when no accept.
REQ-022 A requester withdrawing req_valid before acceptance SHALL not be granted; no starvation: any held request is granted within R accepts.

Reset
REQ-023 While rst_n = 0: out_valid = 0, out_data = 0, out_id = 0, p = 0, req_ready = 0, independent of clk.
REQ-024 Reset asserted with out_valid = 1 SHALL discard the pending result; first accept after release uses p = 0.

Configuration
REQ-025 Macro BARREL_SHIFT_ARBITER_RR_EN defined: round-robin arbitration per REQ-021.
REQ-026 Macro not defined: fixed priority, lowest asserted index wins, pointer register absent; REQ-022 starvation bound not required; all other requirements unchanged.

Verification (N=32, R=4, RR_EN defined unless stated)
REQ-027 Single op: req_valid=0001, req_a[0]=0x8000_0001, req_amt[0]=1, out_ready=1 -> req_ready=0001 same cycle; next cycle out_valid=1, out_data=0x0000_0003, out_id=0.
REQ-028 Rotate bounds: a=0x1234_5678, amt=0 -> 0x1234_5678; amt=31 -> 0x091A_2B3C; amt=16 -> 0x5678_1234.
REQ-029 Contention: req_valid=1111 held for 8 accepts, out_ready=1 -> out_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
REQ-030 Backpressure: out_ready=0 for 3 cycles with out_valid=1 and req_valid=0010 -> out_data/out_id stable, req_ready=0; out_ready=1 -> requester 1 accepted same cycle, result next cycle.
REQ-031 Reset mid-operation: rst_n low while out_valid=1 -> out_valid=0 immediately (no clock edge); after release req_valid=1111 -> first out_id=0.
REQ-032 Macro undefined: req_valid=0110 held 4 accepts -> out_id 1,1,1,1.
